fetch_stage: RTL and testbench

Instruction fetch stage of `proc`, directly upstream of decode. Owns the program counter and issues word reads to instruction memory over a req/ack handshake. Buffers returned instructions with their addresses in a 2-entry queue toward decode. Handles decode back-pressure, branch redirects with flush, and the external PC-enable freeze driven by the bench.

---
 rtl/fetch_stage.sv | 118 +++++++++++
 tb/tb_fetch_stage.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues word reads over req/ack and
// buffers returned instructions with their addresses in a 2-entry queue toward decode.
module fetch_stage #(
  parameter int ADDR_W = 16,
  parameter int INSTR_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable_pc_external,
  input  logic               stall_in,
  input  logic               branch_valid,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc
);

  // Handshakes: imem_req/imem_addr are held until the edge where imem_ack=1;
  // decode takes the head at any edge where out_valid=1 and stall_in=0.
  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   pc;
  logic                tail_valid;
  logic [INSTR_W-1:0]  tail_instr;
  logic [ADDR_W-1:0]   tail_pc;

  logic                pop;
  logic                push;
  logic                free;
  logic                issue;
  logic [1:0]          count;
  logic [1:0]          post_count;
  logic [ADDR_W-1:0]   fetch_base;

  always_comb begin
    pop        = out_valid && !stall_in;
    push       = imem_ack && (state == REQ) && !branch_valid;
    free       = (state == IDLE) || imem_ack;
    count      = {1'b0, out_valid} + {1'b0, tail_valid};
    post_count = '0;
    if (!branch_valid)
      post_count = count + {1'b0, push} - {1'b0, pop};
    // A redirect applies to a request issued on the same edge.
    fetch_base = branch_valid ? branch_target : pc;
    issue      = enable_pc_external && free && (post_count <= 2'd1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      imem_req   <= 1'b0;
      imem_addr  <= '0;
      out_valid  <= 1'b0;
      out_instr  <= '0;
      out_pc     <= '0;
      tail_valid <= 1'b0;
      tail_instr <= '0;
      tail_pc    <= '0;
    end else begin
      // Queue: out_* is the head entry, tail_* the second entry.
      if (branch_valid) begin
        out_valid  <= 1'b0;
        tail_valid <= 1'b0;
      end else if (pop && push) begin
        if (tail_valid) begin
          out_instr  <= tail_instr;
          out_pc     <= tail_pc;
          tail_instr <= imem_rdata;
          tail_pc    <= imem_addr;
        end else begin
          out_instr <= imem_rdata;
          out_pc    <= imem_addr;
        end
      end else if (pop) begin
        out_valid  <= tail_valid;
        tail_valid <= 1'b0;
        if (tail_valid) begin
          out_instr <= tail_instr;
          out_pc    <= tail_pc;
        end
      end else if (push) begin
        if (!out_valid) begin
          out_valid <= 1'b1;
          out_instr <= imem_rdata;
          out_pc    <= imem_addr;
        end else begin
          tail_valid <= 1'b1;
          tail_instr <= imem_rdata;
          tail_pc    <= imem_addr;
        end
      end

      // Request control: an in-flight read is never aborted, only marked DROP.
      if (issue) begin
        imem_req  <= 1'b1;
        imem_addr <= fetch_base;
        pc        <= fetch_base + ADDR_W'(1);
        state     <= REQ;
      end else begin
        pc <= fetch_base;
        if (free) begin
          imem_req <= 1'b0;
          state    <= IDLE;
        end else if (branch_valid) begin
          state <= DROP;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: memory responder with variable latency and a
// program-order reference stream checked by a scoreboard at every decode pop.
module tb_fetch_stage;
  localparam int ADDR_W = 16;
  localparam int INSTR_W = 16;
  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        reset, enable_pc_external, stall_in, branch_valid;
  logic [15:0] branch_target;
  logic        imem_req, imem_ack, out_valid;
  logic [15:0] imem_addr, imem_rdata, out_instr, out_pc;

  int errors = 0;
  int checks = 0;
  int pops = 0;
  int lat_min = 0;
  int lat_max = 0;
  logic [15:0] exp_q[$];
  logic [15:0] fill_pc;
  logic [15:0] exp_req_addr;

  fetch_stage #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .enable_pc_external(enable_pc_external),
    .stall_in(stall_in), .branch_valid(branch_valid), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc)
  );

  // clock/reset block
  always #5 clk = ~clk;

  function automatic logic [15:0] instr_of(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Memory responder: acks after a random wait, checks addresses follow program order.
  initial begin : mem_model
    int wait_c;
    bit busy;
    logic [15:0] held;
    busy = 0; wait_c = 0; held = '0;
    imem_ack = 1'b0; imem_rdata = '0;
    forever begin
      @(negedge clk);
      if (imem_ack || imem_req !== 1'b1) busy = 0;
      imem_ack = 1'b0;
      if (imem_req === 1'b1 && !busy) begin
        busy = 1;
        held = imem_addr;
        wait_c = $urandom_range(lat_max, lat_min);
        check("req_addr", 32'(imem_addr), 32'(exp_req_addr));
        exp_req_addr++;
      end else if (imem_req === 1'b1) begin
        check("addr_stable", 32'(imem_addr), 32'(held));
      end
      if (busy) begin
        if (wait_c == 0) begin
          imem_ack = 1'b1;
          imem_rdata = instr_of(imem_addr);
        end else begin
          wait_c--;
        end
      end
    end
  end

  // Scoreboard/monitor: samples 2 time units before each rising edge.
  initial begin : monitor
    bit chk_rst, chk_flush;
    logic [15:0] exp_pc;
    chk_rst = 0; chk_flush = 0;
    forever begin
      @(negedge clk); #3;
      if (chk_rst) begin
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_imem_req", 32'(imem_req), 0);
        check("rst_imem_addr", 32'(imem_addr), 0);
        check("rst_out_pc", 32'(out_pc), 0);
        check("rst_out_instr", 32'(out_instr), 0);
      end
      if (chk_flush) check("flush_valid", 32'(out_valid), 0);
      chk_rst = 0; chk_flush = 0;
      if (reset) begin
        exp_q.delete();
        fill_pc = RESET_PC;
        exp_req_addr = RESET_PC;
        chk_rst = 1;
      end else if (branch_valid) begin
        exp_q.delete();
        fill_pc = branch_target;
        exp_req_addr = branch_target;
        chk_flush = 1;
      end
      while (exp_q.size() < 4) begin
        exp_q.push_back(fill_pc);
        fill_pc++;
      end
      if (!reset && !branch_valid && out_valid && !stall_in) begin
        exp_pc = exp_q.pop_front();
        check("out_pc", 32'(out_pc), 32'(exp_pc));
        check("out_instr", 32'(out_instr), 32'(instr_of(exp_pc)));
        pops++;
      end
    end
  end

  // driver tasks
  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_pending();
    int n;
    n = 0;
    while (!(imem_req && !imem_ack) && n < 50) begin step(); n++; end
    if (n >= 50) begin errors++; checks++; $display("FAIL wait_pending: timeout after %0d cycles", n); end
  endtask

  task automatic wait_ack();
    int n;
    n = 0;
    while (!imem_ack && n < 50) begin step(); n++; end
    if (n >= 50) begin errors++; checks++; $display("FAIL wait_ack: timeout after %0d cycles", n); end
  endtask

  task automatic do_branch(input logic [15:0] t);
    branch_valid = 1'b1; branch_target = t;
    step();
    branch_valid = 1'b0;
  endtask

  initial begin : driver
    reset = 1'b1; enable_pc_external = 1'b1; stall_in = 1'b0;
    branch_valid = 1'b0; branch_target = '0;
    run(3);
    reset = 1'b0;

    // zero-wait memory: sustained one instruction per cycle
    for (int i = 0; i < 20; i++) begin
      step();
      if (i >= 3) check("stream_valid", 32'(out_valid), 1);
    end

    // back-pressure fills the queue and stops issue
    stall_in = 1'b1;
    run(5);
    check("full_no_req", 32'(imem_req), 0);
    check("full_valid", 32'(out_valid), 1);
    stall_in = 1'b0;
    run(10);

    // branch while a slow request is outstanding
    lat_min = 3; lat_max = 3;
    wait_pending();
    do_branch(16'h0040);
    run(20);

    // branch on the same edge as an ack
    lat_min = 1; lat_max = 1;
    wait_ack();
    do_branch(16'h0080);
    run(10);

    // branch with a full, stalled queue
    lat_min = 0; lat_max = 0;
    stall_in = 1'b1;
    run(4);
    do_branch(16'h00C0);
    stall_in = 1'b0;
    run(10);

    // freeze with one request outstanding
    lat_min = 3; lat_max = 3;
    wait_pending();
    enable_pc_external = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i >= 5) check("frozen_no_req", 32'(imem_req), 0);
    end
    enable_pc_external = 1'b1;
    run(10);

    // PC wrap, then reset mid-request
    lat_min = 0; lat_max = 0;
    do_branch(16'hFFFE);
    run(6);
    lat_min = 3; lat_max = 3;
    wait_pending();
    reset = 1'b1;
    step();
    reset = 1'b0;
    run(10);

    // randomized traffic
    lat_min = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) lat_max = $urandom_range(3, 0);
      stall_in = ($urandom_range(3, 0) == 0);
      enable_pc_external = ($urandom_range(9, 0) != 0);
      branch_valid = !branch_valid && ($urandom_range(19, 0) == 0);
      branch_target = 16'($urandom);
      reset = ($urandom_range(499, 0) == 0);
      step();
    end
    stall_in = 1'b0; branch_valid = 1'b0; reset = 1'b0; enable_pc_external = 1'b1;
    run(20);
    checks++;
    if (pops < 500) begin
      errors++;
      $display("FAIL throughput: got %0d pops expected at least 500", pops);
    end

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
